// File: rtl/life_grid_engine.sv
// Conway's Game of Life on a ROWS x COLS grid: one row per cycle goes into a next buffer, which is committed in one cycle.
// Define TORUS_WRAP_EN for a toroidal grid. Without it, cells beyond the edge read as dead.
module life_cell (
    input  logic       self,
    input  logic [7:0] nbr,
    output logic       nxt
);
    logic [3:0] cnt;

    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, nbr[i]};
    end

    // B3/S23
    assign nxt = (cnt == 4'd3) || (self && (cnt == 4'd2));
endmodule

module life_grid_engine #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int GEN_W   = 16,
    parameter int RUN_DIV = 50000000
) (
    input  logic                    ClkPort,
    input  logic                    Resetn,
    input  logic                    clear_i,
    input  logic                    load_valid_i,
    input  logic [$clog2(ROWS)-1:0] load_row_i,
    input  logic [COLS-1:0]         load_data_i,
    input  logic                    step_i,
    input  logic                    run_i,
    output logic [ROWS*COLS-1:0]    board_o,
    output logic [GEN_W-1:0]        generation_cnt_o,
    output logic                    busy_o,
    output logic                    stable_o,
    output logic                    extinct_o
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int DIV_W = $clog2(RUN_DIV + 1);
`ifdef TORUS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [ROW_W:0]   ROWS_L   = (ROW_W + 1)'(ROWS);

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t                    state;
    logic [ROWS-1:0][COLS-1:0] board, next_buf;
    logic [ROW_W-1:0]          row;
    logic [DIV_W-1:0]          div;
    logic                      run_pend;
    logic [GEN_W-1:0]          gen_cnt;
    logic                      busy, stable, extinct;

    logic [ROW_W-1:0] up_idx, dn_idx;
    logic [COLS-1:0]  up_row, mid_row, dn_row, new_row;
    logic [COLS+1:0]  up_ext, mid_ext, dn_ext;
    logic             div_exp, start, load_hit, taken;

    // Neighbour rows for the row being computed. Each row is padded with the column -1 / COLS halo.
    always_comb begin
        up_idx  = (row == '0) ? LAST_ROW : row - ROW_W'(1);
        dn_idx  = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        up_row  = (WRAP || row != '0) ? board[up_idx] : '0;
        mid_row = board[row];
        dn_row  = (WRAP || row != LAST_ROW) ? board[dn_idx] : '0;
        up_ext  = {WRAP & up_row[0],  up_row,  WRAP & up_row[COLS-1]};
        mid_ext = {WRAP & mid_row[0], mid_row, WRAP & mid_row[COLS-1]};
        dn_ext  = {WRAP & dn_row[0],  dn_row,  WRAP & dn_row[COLS-1]};
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        life_cell u_cell (
            .self (mid_ext[c+1]),
            .nbr  ({up_ext[c], up_ext[c+1], up_ext[c+2], mid_ext[c], mid_ext[c+2],
                    dn_ext[c], dn_ext[c+1], dn_ext[c+2]}),
            .nxt  (new_row[c])
        );
    end

    // A divider expiry that lands while busy is held in run_pend until the next IDLE cycle.
    assign div_exp  = run_i && (div == DIV_LAST);
    assign start    = run_i ? (div_exp || run_pend) : step_i;
    assign load_hit = load_valid_i && ({1'b0, load_row_i} < ROWS_L);
    assign taken    = (state == IDLE) && !clear_i && !load_hit && start;

    always_ff @(posedge ClkPort or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            board    <= '0;
            next_buf <= '0;
            row      <= '0;
            div      <= '0;
            run_pend <= 1'b0;
            gen_cnt  <= '0;
            busy     <= 1'b0;
            stable   <= 1'b0;
            extinct  <= 1'b1;
        end else begin
            div      <= run_i ? (div_exp ? '0 : div + DIV_W'(1)) : '0;
            run_pend <= run_i && (run_pend || div_exp) && !taken;
            case (state)
                IDLE: begin
                    extinct <= (board == '0);
                    if (clear_i) begin
                        board   <= '0;
                        gen_cnt <= '0;
                        stable  <= 1'b0;
                        extinct <= 1'b1;
                    end else if (load_hit) begin
                        board[load_row_i] <= load_data_i;
                        gen_cnt           <= '0;
                        stable            <= 1'b0;
                    end else if (start) begin
                        state <= COMPUTE;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    next_buf[row] <= new_row;
                    if (row == LAST_ROW) state <= COMMIT;
                    else                 row   <= row + ROW_W'(1);
                end
                COMMIT: begin
                    board   <= next_buf;
                    gen_cnt <= gen_cnt + GEN_W'(1);
                    stable  <= (next_buf == board);
                    extinct <= (next_buf == '0);
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign board_o          = board;
    assign generation_cnt_o = gen_cnt;
    assign busy_o           = busy;
    assign stable_o         = stable;
    assign extinct_o        = extinct;
endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine. It compares the DUT against an array-based Game of Life model.
module tb_life_grid_engine;
    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int GEN_W   = 4;
    localparam int RUN_DIV = 20;
    localparam int NB      = ROWS * COLS;

    logic                    ClkPort = 1'b0;
    logic                    Resetn = 1'b0;
    logic                    clear_i = 1'b0;
    logic                    load_valid_i = 1'b0;
    logic [$clog2(ROWS)-1:0] load_row_i = '0;
    logic [COLS-1:0]         load_data_i = '0;
    logic                    step_i = 1'b0;
    logic                    run_i = 1'b0;
    logic [NB-1:0]           board_o;
    logic [GEN_W-1:0]        generation_cnt_o;
    logic                    busy_o, stable_o, extinct_o;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    bit mb[ROWS][COLS];
    int mcnt = 0;
    bit mstable = 0;
    bit mext = 1;

    life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .RUN_DIV(RUN_DIV)) dut (
        .ClkPort(ClkPort), .Resetn(Resetn), .clear_i(clear_i), .load_valid_i(load_valid_i),
        .load_row_i(load_row_i), .load_data_i(load_data_i), .step_i(step_i), .run_i(run_i),
        .board_o(board_o), .generation_cnt_o(generation_cnt_o), .busy_o(busy_o),
        .stable_o(stable_o), .extinct_o(extinct_o)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ClkPort);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] mflat();
        logic [NB-1:0] f = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) f[r*COLS+c] = mb[r][c];
        return f;
    endfunction

    task automatic mclear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mb[r][c] = 1'b0;
        mcnt = 0; mstable = 0; mext = 1;
    endtask

    task automatic mstep();
        bit nb[ROWS][COLS];
        bit same = 1;
        bit dead = 1;
        int n, rr, cc;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr; cc = c + dc;
`ifdef TORUS_WRAP_EN
                        rr = (rr + ROWS) % ROWS; cc = (cc + COLS) % COLS;
`endif
                        if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) n += int'(mb[rr][cc]);
                    end
                nb[r][c] = (n == 3) || (mb[r][c] && n == 2);
            end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                same &= (nb[r][c] == mb[r][c]);
                dead &= !nb[r][c];
            end
        mb = nb;
        mcnt = (mcnt + 1) % (1 << GEN_W);
        mstable = same;
        mext = dead;
    endtask

    task automatic chk_state();
        chk("board", board_o, mflat());
        chk("gen_cnt", NB'(generation_cnt_o), NB'(mcnt));
        chk("stable", NB'(stable_o), NB'(mstable));
        chk("extinct", NB'(extinct_o), NB'(mext));
    endtask

    task automatic do_clear();
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        mclear();
    endtask

    task automatic do_load(input int r, input logic [COLS-1:0] d);
        load_row_i = ($clog2(ROWS))'(r); load_data_i = d; load_valid_i = 1'b1;
        tick();
        load_valid_i = 1'b0;
        for (int c = 0; c < COLS; c++) mb[r][c] = d[c];
        mcnt = 0; mstable = 0;
        mext = (mflat() == '0);
    endtask

    task automatic do_step();
        int n = 0;
        step_i = 1'b1; tick(); step_i = 1'b0;
        chk("busy_start", NB'(busy_o), NB'(1));
        while (busy_o && n < 60) begin
            if (n == 5) chk("board_hold", board_o, mflat());
            tick(); n++;
        end
        chk("latency", NB'(n), NB'(ROWS + 1));
        mstep();
        chk_state();
    endtask

    initial begin
        logic [NB-1:0] exp;
        int n, t, tprev;
        tick(); tick();
        chk("rst_board", board_o, '0);
        chk("rst_gen", NB'(generation_cnt_o), '0);
        chk("rst_busy", NB'(busy_o), '0);
        chk("rst_stable", NB'(stable_o), '0);
        chk("rst_extinct", NB'(extinct_o), NB'(1));
        Resetn = 1'b1; tick();
        mclear();

        // blinker oscillates with period 2
        do_load(8, 16'h0380); tick();
        chk("ext_after_load", NB'(extinct_o), '0);
        do_step();
        exp = '0; exp[7*COLS+8] = 1'b1; exp[8*COLS+8] = 1'b1; exp[9*COLS+8] = 1'b1;
        chk("blinker_v", board_o, exp);
        do_step();
        chk("blinker_h", board_o, NB'(16'h0380) << (8 * COLS));

        do_clear(); tick();
        chk_state();
        do_load(4, 16'h0030); do_load(5, 16'h0030);
        do_step();
        chk("block_stable", NB'(stable_o), NB'(1));

        do_clear(); do_load(0, 16'h0001);
        do_step(); do_step();

        // glider heading up-left into the (0,0) corner
        do_clear(); do_load(0, 16'h0007); do_load(1, 16'h0001); do_load(2, 16'h0002);
        repeat (4) do_step();
`ifdef TORUS_WRAP_EN
        chk("glider_pop", NB'($countones(board_o)), NB'(5));
`endif

        for (int k = 0; k < 2; k++) begin
            do_clear();
            for (int r = 0; r < ROWS; r++) do_load(r, COLS'($urandom));
            repeat (3) do_step();
        end

        // free-run: a start every RUN_DIV cycles, the counter wraps, and commands sent while busy are dropped
        do_clear(); do_load(8, 16'h0380);
        run_i = 1'b1;
        tprev = 0;
        for (int g = 1; g <= 17; g++) begin
            n = 0;
            while (!busy_o && n < 60) begin tick(); n++; end
            chk("run_start", NB'(busy_o), NB'(1));
            t = cyc;
            if (g > 1) chk("run_period", NB'(t - tprev), NB'(RUN_DIV));
            tprev = t;
            if (g == 3) begin
                repeat (5) tick();
                step_i = 1'b1; clear_i = 1'b1; load_valid_i = 1'b1;
                load_row_i = '0; load_data_i = '1;
                tick();
                step_i = 1'b0; clear_i = 1'b0; load_valid_i = 1'b0;
            end
            n = 0;
            while (busy_o && n < 60) begin tick(); n++; end
            chk("run_done", NB'(busy_o), '0);
            mstep();
            chk_state();
            if (g == 16) chk("gen_wrap", NB'(generation_cnt_o), '0);
        end
        run_i = 1'b0;
        repeat (25) tick();
        chk("run_stop", NB'(busy_o), '0);
        chk("run_stop_board", board_o, mflat());

        // reset while COMPUTE is working on row 5
        do_clear(); do_load(8, 16'h0380);
        step_i = 1'b1; tick(); step_i = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", NB'(busy_o), NB'(1));
        Resetn = 1'b0; #1;
        chk("mid_rst_board", board_o, '0);
        chk("mid_rst_gen", NB'(generation_cnt_o), '0);
        chk("mid_rst_busy", NB'(busy_o), '0);
        chk("mid_rst_stable", NB'(stable_o), '0);
        chk("mid_rst_extinct", NB'(extinct_o), NB'(1));
        tick(); Resetn = 1'b1; mclear();
        tick();
        do_step();
        chk("post_rst_gen", NB'(generation_cnt_o), NB'(1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
